// File: rtl/sbox_builder.sv
// S-box table builder: collects unique bytes from a chaotic stream into a 256-entry
// forward table. Define INV_SBOX_EN to add the inverse table and the lk_inv_data port.
module sbox_builder (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cand_valid,
  input  logic [7:0] cand_data,
  input  logic       dup_in,
  output logic       cand_ready,
  output logic       busy,
  output logic       done,
  output logic [8:0] fill_count,
  input  logic [7:0] lk_addr,
  output logic [7:0] lk_data
`ifdef INV_SBOX_EN
  ,
  output logic [7:0] lk_inv_data
`endif
);

  // state   | meaning
  // IDLE    | waiting for start, candidates ignored
  // COLLECT | accepting candidates, committing non-duplicates
  // DONE    | all 256 entries written, table valid for lookup
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t     state;
  logic       cand_valid_d;
  logic [7:0] cand_d;
  logic       commit;
  logic [7:0] tbl [256];

  assign cand_ready = (state == COLLECT);

  // The detector's verdict arrives one cycle late, so the commit acts on the delayed candidate.
  assign commit = (state == COLLECT) && cand_valid_d && !dup_in && !start;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      fill_count   <= '0;
      cand_valid_d <= 1'b0;
      cand_d       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      cand_valid_d <= cand_valid && (state == COLLECT) && !start;
      cand_d       <= cand_data;
      if (start) begin
        state        <= COLLECT;
        fill_count   <= '0;
        busy         <= 1'b1;
        done         <= 1'b0;
      end else if (commit) begin
        fill_count <= fill_count + 9'd1;
        if (fill_count == 9'd255) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (commit)
      tbl[fill_count[7:0]] <= cand_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      lk_data <= '0;
    else
      lk_data <= tbl[lk_addr];
  end

`ifdef INV_SBOX_EN
  logic [7:0] inv_tbl [256];

  always_ff @(posedge clk) begin
    if (commit)
      inv_tbl[cand_d] <= fill_count[7:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      lk_inv_data <= '0;
    else
      lk_inv_data <= inv_tbl[lk_addr];
  end
`endif

endmodule

// File: tb/tb_sbox_builder.sv
// Bench for sbox_builder: directed builds plus a randomized build checked against
// a list-of-unique-bytes reference model.
module tb_sbox_builder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       cand_valid = 1'b0;
  logic [7:0] cand_data = '0;
  logic       dup_in = 1'b0;
  logic       cand_ready;
  logic       busy;
  logic       done;
  logic [8:0] fill_count;
  logic [7:0] lk_addr = '0;
  logic [7:0] lk_data;
`ifdef INV_SBOX_EN
  logic [7:0] lk_inv_data;
`endif

  int checks = 0;
  int failures = 0;
  logic nxt_dup = 1'b0;

  logic [7:0] exp_tbl [256];
  logic [7:0] exp_inv [256];
  bit         seen [256];
  int         exp_n;

  sbox_builder dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .cand_valid(cand_valid),
    .cand_data(cand_data),
    .dup_in(dup_in),
    .cand_ready(cand_ready),
    .busy(busy),
    .done(done),
    .fill_count(fill_count),
    .lk_addr(lk_addr),
    .lk_data(lk_data)
`ifdef INV_SBOX_EN
    ,
    .lk_inv_data(lk_inv_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one candidate; its duplicate verdict is driven on the following cycle.
  task automatic cyc(input logic v, input logic [7:0] b, input logic d);
    start      = 1'b0;
    cand_valid = v;
    cand_data  = b;
    dup_in     = nxt_dup;
    nxt_dup    = v & d;
    tick();
  endtask

  task automatic start_build();
    start      = 1'b1;
    cand_valid = 1'b0;
    dup_in     = nxt_dup;
    nxt_dup    = 1'b0;
    tick();
    start      = 1'b0;
  endtask

  task automatic lookup(input logic [7:0] a);
    cand_valid = 1'b0;
    dup_in     = 1'b0;
    lk_addr    = a;
    tick();
  endtask

  initial begin
    logic       v, d, pv, pd, cp;
    logic [7:0] b, pb;
    int         idx;

    // Reset state
    #1;
    chk("rst_fill", 16'(fill_count), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_ready", 16'(cand_ready), 16'd0);
    chk("rst_lk", 16'(lk_data), 16'd0);
    tick();
    tick();
    rst = 1'b1;
    cyc(1'b1, 8'h12, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("idle_ignore", 16'(fill_count), 16'd0);

    // Ascending 0..255, no duplicates
    start_build();
    chk("start_busy", 16'(busy), 16'd1);
    chk("start_ready", 16'(cand_ready), 16'd1);
    for (int i = 0; i < 256; i++) cyc(1'b1, 8'(i), 1'b0);
    chk("asc_done_early", 16'(done), 16'd0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("asc_done", 16'(done), 16'd1);
    chk("asc_fill", 16'(fill_count), 16'd256);
    chk("asc_busy", 16'(busy), 16'd0);
    lookup(8'h37);
    chk("asc_lk37", 16'(lk_data), 16'h37);
`ifdef INV_SBOX_EN
    chk("asc_inv37", 16'(lk_inv_data), 16'h37);
`endif

    // Duplicate discard: 05,05,09 with verdicts 0,1,0
    start_build();
    cyc(1'b1, 8'h05, 1'b0);
    cyc(1'b1, 8'h05, 1'b1);
    cyc(1'b1, 8'h09, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("dup_fill", 16'(fill_count), 16'd2);
    for (int i = 0; i < 256; i++)
      if (i != 5 && i != 9) cyc(1'b1, 8'(i), 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("dup_done", 16'(done), 16'd1);
    lookup(8'd0);
    chk("dup_t0", 16'(lk_data), 16'h05);
    lookup(8'd1);
    chk("dup_t1", 16'(lk_data), 16'h09);
    lookup(8'd2);
    chk("dup_t2", 16'(lk_data), 16'h00);

    // Candidates after done are ignored
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'($urandom_range(255)), 1'($urandom_range(1)));
    cyc(1'b0, 8'h00, 1'b0);
    chk("post_fill", 16'(fill_count), 16'd256);
    chk("post_done", 16'(done), 16'd1);
    lookup(8'd0);
    chk("post_t0", 16'(lk_data), 16'h05);
    lookup(8'd255);
    chk("post_t255", 16'(lk_data), 16'hFF);

    // Descending build: table[i] = 255-i
    start_build();
    for (int i = 0; i < 256; i++) cyc(1'b1, 8'(255 - i), 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("desc_done", 16'(done), 16'd1);
    lookup(8'h00);
    chk("desc_lk00", 16'(lk_data), 16'hFF);
`ifdef INV_SBOX_EN
    chk("desc_inv00", 16'(lk_inv_data), 16'hFF);
`endif
    lookup(8'h10);
    chk("desc_lk10", 16'(lk_data), 16'hEF);
`ifdef INV_SBOX_EN
    chk("desc_inv10", 16'(lk_inv_data), 16'hEF);
`endif

    // Randomized build against the model
    start_build();
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    exp_n = 0;
    pv = 1'b0; pd = 1'b0; pb = '0;
    for (int i = 0; i < 10000 && exp_n < 256; i++) begin
      v = ($urandom_range(3) != 0);
      b = 8'($urandom_range(255));
      d = seen[b];
      if (v && !d) seen[b] = 1'b1;
      cp = pv && !pd;
      cyc(v, b, d);
      if (cp) begin
        exp_tbl[exp_n] = pb;
        exp_inv[pb] = 8'(exp_n);
        exp_n++;
      end
      pv = v; pd = d; pb = b;
      chk("rnd_fill", 16'(fill_count), 16'(exp_n));
      chk("rnd_done", 16'(done), 16'(exp_n == 256));
    end
    chk("rnd_complete", 16'(exp_n), 16'd256);
    cyc(1'b0, 8'h00, 1'b0);
    for (int a = 0; a < 256; a++) begin
      lookup(8'(a));
      chk("rnd_lk", 16'(lk_data), 16'(exp_tbl[a]));
`ifdef INV_SBOX_EN
      chk("rnd_inv", 16'(lk_inv_data), 16'(exp_inv[a]));
`endif
    end

    // Reset mid-collect at fill_count=100
    start_build();
    for (int i = 0; i < 100; i++) cyc(1'b1, 8'(i), 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("mid_fill", 16'(fill_count), 16'd100);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_fill", 16'(fill_count), 16'd0);
    chk("mid_rst_busy", 16'(busy), 16'd0);
    chk("mid_rst_ready", 16'(cand_ready), 16'd0);
    chk("mid_rst_lk", 16'(lk_data), 16'd0);
    #3 rst = 1'b1;
    nxt_dup = 1'b0;
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(200 + i), 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("mid_ignore_fill", 16'(fill_count), 16'd0);
    chk("mid_ignore_busy", 16'(busy), 16'd0);

    // Start collides with the commit at fill_count=10
    start_build();
    for (idx = 0; idx < 10; idx++) cyc(1'b1, 8'(idx), 1'b0);
    cyc(1'b1, 8'hAA, 1'b0);
    chk("coll_fill10", 16'(fill_count), 16'd10);
    start_build();
    chk("coll_fill0", 16'(fill_count), 16'd0);
    chk("coll_busy", 16'(busy), 16'd1);
    lookup(8'd10);
    chk("coll_t10", 16'(lk_data), 16'h0A);
    chk("coll_fill_hold", 16'(fill_count), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
